// File: rtl/rtl_control_unit.sv
// Hardwired control unit: runs a three-step fetch, then decodes ir into execute steps T3-T7.
// All strobes are combinational decodes of the current step, ir and (only in branch T5) con_ff.
module rtl_control_unit (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir,
    input  logic        con_ff,
    output logic [15:0] enable_GPR,
    output logic [15:0] select_E,
    output logic        enable_PC,
    output logic        enable_IR,
    output logic        enable_MAR,
    output logic        enable_MDR,
    output logic        enable_Y,
    output logic        enable_ZLO,
    output logic        select_PC,
    output logic        select_MDR,
    output logic        select_ZLO,
    output logic        select_C,
    output logic        inc_pc,
    output logic [1:0]  read,
    output logic        mem_write,
    output logic [4:0]  alu_op,
    output logic        run,
    output logic [3:0]  state_dbg
);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_ST   = 5'b00001;
    localparam logic [4:0] OP_ADD  = 5'b00010;
    localparam logic [4:0] OP_SUB  = 5'b00011;
    localparam logic [4:0] OP_AND  = 5'b00100;
    localparam logic [4:0] OP_OR   = 5'b00101;
    localparam logic [4:0] OP_ADDI = 5'b00110;
    localparam logic [4:0] OP_BR   = 5'b00111;
    localparam logic [4:0] OP_HALT = 5'b11111;

    localparam logic [4:0] ALU_ADD = 5'd0;
    localparam logic [4:0] ALU_SUB = 5'd1;
    localparam logic [4:0] ALU_AND = 5'd2;
    localparam logic [4:0] ALU_OR  = 5'd3;

    state_t state, state_next;

    logic [4:0] opcode;
    logic [3:0] ra, rb, rc;
    logic       is_alu, is_addi, is_mem, is_br, is_halt;
    logic       unused_ir_bits;

    assign opcode  = ir[31:27];
    assign ra      = ir[26:23];
    assign rb      = ir[22:19];
    assign rc      = ir[18:15];
    assign is_alu  = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                     (opcode == OP_AND) || (opcode == OP_OR);
    assign is_addi = (opcode == OP_ADDI);
    assign is_mem  = (opcode == OP_LD) || (opcode == OP_ST);
    assign is_br   = (opcode == OP_BR);
    assign is_halt = (opcode == OP_HALT);
    assign unused_ir_bits = ^ir[14:0];
    assign state_dbg = state;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        enable_GPR = 16'h0000;
        select_E   = 16'h0000;
        enable_PC  = 1'b0;
        enable_IR  = 1'b0;
        enable_MAR = 1'b0;
        enable_MDR = 1'b0;
        enable_Y   = 1'b0;
        enable_ZLO = 1'b0;
        select_PC  = 1'b0;
        select_MDR = 1'b0;
        select_ZLO = 1'b0;
        select_C   = 1'b0;
        inc_pc     = 1'b0;
        read       = 2'b00;
        mem_write  = 1'b0;
        alu_op     = ALU_ADD;
        run        = 1'b1;

        case (state)
            S_IDLE: begin
                run        = 1'b0;
                state_next = S_T0;
            end
            S_T0: begin
                select_PC  = 1'b1;
                enable_MAR = 1'b1;
                inc_pc     = 1'b1;
                state_next = S_T1;
            end
            S_T1: begin
                read       = 2'b01;
                enable_MDR = 1'b1;
                state_next = S_T2;
            end
            S_T2: begin
                select_MDR = 1'b1;
                enable_IR  = 1'b1;
                state_next = S_T3;
            end
            S_T3: begin
                if (is_alu || is_addi || is_mem) begin
                    select_E = 16'h0001 << rb;
                    enable_Y = 1'b1;
                end else if (is_br) begin
                    select_PC = 1'b1;
                    enable_Y  = 1'b1;
                end
                if (is_halt)                                state_next = S_HALT;
                else if (is_alu || is_addi || is_mem || is_br) state_next = S_T4;
                else                                        state_next = S_T0;
            end
            S_T4: begin
                // Only the register-register ALU ops take the second operand from rc.
                if (is_alu) begin
                    select_E = 16'h0001 << rc;
                    case (opcode)
                        OP_SUB:  alu_op = ALU_SUB;
                        OP_AND:  alu_op = ALU_AND;
                        OP_OR:   alu_op = ALU_OR;
                        default: alu_op = ALU_ADD;
                    endcase
                end else begin
                    select_C = 1'b1;
                end
                enable_ZLO = 1'b1;
                state_next = S_T5;
            end
            S_T5: begin
                if (is_alu || is_addi) begin
                    select_ZLO = 1'b1;
                    enable_GPR = 16'h0001 << ra;
                end else if (is_mem) begin
                    select_ZLO = 1'b1;
                    enable_MAR = 1'b1;
                end else if (is_br && con_ff) begin
                    select_ZLO = 1'b1;
                    enable_PC  = 1'b1;
                end
                state_next = is_mem ? S_T6 : S_T0;
            end
            S_T6: begin
                if (opcode == OP_ST) begin
                    select_E = 16'h0001 << ra;
                    read     = 2'b00;
                end else begin
                    read     = 2'b01;
                end
                enable_MDR = 1'b1;
                state_next = S_T7;
            end
            S_T7: begin
                if (opcode == OP_ST) begin
                    mem_write = 1'b1;
                end else begin
                    select_MDR = 1'b1;
                    enable_GPR = 16'h0001 << ra;
                end
                state_next = S_T0;
            end
            S_HALT: begin
                run        = 1'b0;
                state_next = S_HALT;
            end
            default: begin
                run        = 1'b0;
                state_next = S_IDLE;
            end
        endcase
    end

endmodule
